// File: rtl/cam_word_queue_if.sv
// Capture-side push port and serializer-side write port of the camera word queue.
// The queue itself takes the slave view; capture logic and serializer take master.
interface cam_word_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  push_i;
    logic [31:0]           push_data_i;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic [15:0]           drop_count_o;
    logic                  ser_wr_o;
    logic [31:0]           ser_data_o;
    logic                  ser_busy_i;

    modport master (
        output push_i, push_data_i, ser_busy_i,
        input  full_o, level_o, drop_count_o, ser_wr_o, ser_data_o
    );

    modport slave (
        input  push_i, push_data_i, ser_busy_i,
        output full_o, level_o, drop_count_o, ser_wr_o, ser_data_o
    );
endinterface

// File: rtl/cam_word_queue.sv
// Elastic word queue feeding the camera-port serializer one word at a time,
// with overflow drop counting and a sequence-numbered idle heartbeat.
module cam_word_queue #(
    parameter int          DEPTH_LOG2       = 4,
    parameter int unsigned HEARTBEAT_CYCLES = 54000000
) (
    input  logic            clk_i,
    input  logic            rst_n,
    cam_word_queue_if.slave bus
);
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam int          PW      = DEPTH_LOG2 + 1;
    localparam bit          HB_EN   = (HEARTBEAT_CYCLES != 0);
    localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW-1:0] wptr_n, rptr_n;
    logic [PW-1:0] level_q;
    logic          full_q;
    logic [15:0]   drop_q;
    logic [31:0]   data_q;
    logic [15:0]   hb_seq_q;
    logic [31:0]   quiet_q;

    logic empty;
    logic push_ok;
    logic quiet;
    logic pop;
    logic hb_fire;
    logic ser_wr;

    assign empty   = (wptr_q == rptr_q);
    assign push_ok = bus.push_i && !full_q;
    assign quiet   = (state_q == IDLE) && empty && !bus.ser_busy_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (pop || hb_fire) state_n = ISSUE;
            ISSUE:   state_n = SETTLE;
            SETTLE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Queued data always wins over a heartbeat.
    always_comb begin
        pop     = 1'b0;
        hb_fire = 1'b0;
        ser_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop     = !empty && !bus.ser_busy_i;
                hb_fire = HB_EN && quiet && (quiet_q == HB_LAST);
            end
            ISSUE:   ser_wr = 1'b1;
            default: ;
        endcase
    end

    assign wptr_n = wptr_q + PW'(push_ok);
    assign rptr_n = rptr_q + PW'(pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= bus.push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_n;
            rptr_q  <= rptr_n;
            level_q <= wptr_n - rptr_n;
            full_q  <= (wptr_n[DEPTH_LOG2-1:0] == rptr_n[DEPTH_LOG2-1:0])
                    && (wptr_n[DEPTH_LOG2] != rptr_n[DEPTH_LOG2]);
            if (bus.push_i && full_q && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            hb_seq_q <= '0;
            quiet_q  <= '0;
        end else begin
            if (pop) begin
                data_q <= mem[rptr_q[DEPTH_LOG2-1:0]];
            end else if (hb_fire) begin
                data_q   <= {16'hC0FE, hb_seq_q};
                hb_seq_q <= hb_seq_q + 16'd1;
            end
            if (quiet && !hb_fire) begin
                quiet_q <= quiet_q + 32'd1;
            end else begin
                quiet_q <= '0;
            end
        end
    end

    assign bus.ser_wr_o     = ser_wr;
    assign bus.ser_data_o   = data_q;
    assign bus.level_o      = level_q;
    assign bus.full_o       = full_q;
    assign bus.drop_count_o = drop_q;
endmodule

// File: tb/tb_cam_word_queue.sv
// Bench for cam_word_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_cam_word_queue;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int HB    = 100;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk_i = ~clk_i;

    cam_word_queue_if #(.DEPTH_LOG2(DL2)) bus ();

    cam_word_queue #(
        .DEPTH_LOG2      (DL2),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: visible queue contents, cycles until issue is allowed
    // again, quiet-cycle count, heartbeat sequence, drop counter.
    logic [31:0] mq[$];
    int          m_hold;
    int          m_quiet;
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    logic        m_wr;
    logic [31:0] m_data;

    function automatic void model_reset();
        mq.delete();
        m_hold  = 0;
        m_quiet = 0;
        m_seq   = '0;
        m_drop  = '0;
        m_wr    = 1'b0;
        m_data  = '0;
    endfunction

    function automatic void model_edge(logic p, logic [31:0] d, logic b);
        bit idle;
        bit go_pop;
        bit go_hb;
        int sz;
        sz     = mq.size();
        idle   = (m_hold == 0);
        go_pop = idle && !b && sz > 0;
        go_hb  = idle && !b && sz == 0 && m_quiet == HB - 1;
        m_wr   = go_pop || go_hb;
        if (go_pop) begin
            m_data = mq.pop_front();
        end else if (go_hb) begin
            m_data = {16'hC0FE, m_seq};
            m_seq  = m_seq + 16'd1;
        end
        if (idle && !b && sz == 0 && !go_hb) m_quiet++;
        else m_quiet = 0;
        if (p) begin
            if (sz < DEPTH) mq.push_back(d);
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (m_wr) m_hold = 2;
        else if (m_hold > 0) m_hold--;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_pack();
        return {9'd0, bus.ser_wr_o, bus.ser_data_o, bus.level_o,
                bus.full_o, bus.drop_count_o};
    endfunction

    function automatic logic [63:0] mdl_pack();
        logic [4:0] lv;
        lv = 5'(mq.size());
        return {9'd0, m_wr, m_data, lv, (mq.size() == DEPTH), m_drop};
    endfunction

    // One clock: drive inputs, advance model, compare just after the edge.
    task automatic step(input logic p, input logic [31:0] d, input logic b);
        bus.push_i      = p;
        bus.push_data_i = d;
        bus.ser_busy_i  = b;
        model_edge(p, d, b);
        @(posedge clk_i);
        #1;
        chk("model", dut_pack(), mdl_pack());
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.push_i      = 1'b0;
        bus.push_data_i = '0;
        bus.ser_busy_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        busy;
        logic        wr;
        logic [31:0] exp_data;
        logic [4:0]  lvl;
        logic        full;
        logic [15:0] drop;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] got[$];
        int          bcnt;
        int          lastb;
        int          bad;
        int          hb_at[$];
        logic [31:0] hb_dat[$];

        tbl[0] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, 5'd1, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 5'd0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h12345678, 5'd0, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h12345678, 5'd0, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 32'hAAAA0001, 1'b1, 1'b0, 32'h12345678, 5'd1, 1'b0, 16'd0};
        tbl[5] = '{1'b1, 32'hBBBB0002, 1'b1, 1'b0, 32'h12345678, 5'd2, 1'b0, 16'd0};
        tbl[6] = '{1'b1, 32'hCCCC0003, 1'b1, 1'b0, 32'h12345678, 5'd3, 1'b0, 16'd0};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h12345678, 5'd3, 1'b0, 16'd0};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h12345678, 5'd3, 1'b0, 16'd0};

        do_reset();
        chk("reset_outputs", dut_pack(), 64'd0);

        // Single word, then A/B/C held off by busy.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].push, tbl[i].data, tbl[i].busy);
            chk($sformatf("vec%0d", i), dut_pack(),
                {9'd0, tbl[i].wr, tbl[i].exp_data, tbl[i].lvl,
                 tbl[i].full, tbl[i].drop});
        end

        // Serializer busy for 40 cycles after each write.
        bcnt  = 0;
        lastb = 0;
        bad   = 0;
        got.delete();
        for (int s = 1; s < 400 && got.size() < 3; s++) begin
            logic b;
            b = (bcnt > 0);
            if (b) lastb = s;
            step(1'b0, 32'h0, b);
            if (bcnt > 0) bcnt--;
            if (bus.ser_wr_o) begin
                got.push_back(bus.ser_data_o);
                if (lastb >= s) bad++;
                bcnt = 40;
            end
        end
        chk("holdoff_count", 64'(got.size()), 64'd3);
        chk("holdoff_busy", 64'(bad), 64'd0);
        if (got.size() == 3) begin
            chk("holdoff_order", {got[0], got[1]}, {32'hAAAA0001, 32'hBBBB0002});
            chk("holdoff_last", 64'(got[2]), 64'hCCCC0003);
        end

        // Overflow: 20 pushes into 16 slots with busy held.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'hA0000000 + 32'(i), 1'b1);
        chk("ovf_full", 64'(bus.full_o), 64'd1);
        chk("ovf_level", 64'(bus.level_o), 64'd16);
        chk("ovf_drop", 64'(bus.drop_count_o), 64'd4);
        step(1'b1, 32'hDEADBEEF, 1'b0);
        chk("ovf_pushpop_drop", 64'(bus.drop_count_o), 64'd5);
        chk("ovf_pushpop_level", 64'(bus.level_o), 64'd15);
        got.delete();
        if (bus.ser_wr_o) got.push_back(bus.ser_data_o);
        for (int s = 0; s < 200 && got.size() < 16; s++) begin
            step(1'b0, 32'h0, 1'b0);
            if (bus.ser_wr_o) got.push_back(bus.ser_data_o);
        end
        chk("ovf_drain_count", 64'(got.size()), 64'd16);
        bad = 0;
        foreach (got[k]) if (got[k] !== 32'hA0000000 + 32'(k)) bad++;
        chk("ovf_drain_order", 64'(bad), 64'd0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk("ovf_empty", 64'(bus.level_o), 64'd0);

        // Push coinciding with a pop at level 1.
        step(1'b1, 32'h11110001, 1'b1);
        chk("pp_level_before", 64'(bus.level_o), 64'd1);
        step(1'b1, 32'h11110002, 1'b0);
        chk("pp_level", 64'(bus.level_o), 64'd1);
        chk("pp_drop", 64'(bus.drop_count_o), 64'd5);
        chk("pp_word", {31'd0, bus.ser_wr_o, bus.ser_data_o},
            {31'd0, 1'b1, 32'h11110001});
        repeat (6) step(1'b0, 32'h0, 1'b0);

        // Heartbeat timing, then a push restarting the quiet count.
        do_reset();
        hb_at.delete();
        hb_dat.delete();
        for (int s = 1; s <= 440; s++) begin
            step(s == 330, 32'h00000055, 1'b0);
            if (bus.ser_wr_o) begin
                hb_at.push_back(s);
                hb_dat.push_back(bus.ser_data_o);
            end
        end
        chk("hb_count", 64'(hb_at.size()), 64'd5);
        if (hb_at.size() == 5) begin
            chk("hb0_at", 64'(hb_at[0]), 64'd100);
            chk("hb0_data", 64'(hb_dat[0]), 64'hC0FE0000);
            chk("hb1_at", 64'(hb_at[1]), 64'd202);
            chk("hb1_data", 64'(hb_dat[1]), 64'hC0FE0001);
            chk("hb2_at", 64'(hb_at[2]), 64'd304);
            chk("push_at", {32'(hb_at[3]), hb_dat[3]}, {32'd331, 32'h00000055});
            chk("hb_restart", {32'(hb_at[4]), hb_dat[4]}, {32'd433, 32'hC0FE0003});
        end

        // Reset asserted during ISSUE with words queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hB0000000 + 32'(i), 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk("rst_pre_issue", 64'(bus.ser_wr_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", dut_pack(), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        bad   = 0;
        for (int s = 0; s < 30; s++) begin
            step(1'b0, 32'h0, 1'b0);
            if (bus.ser_wr_o) bad++;
        end
        chk("rst_no_stale", 64'(bad), 64'd0);

        // Randomized traffic with a serializer that stays busy a while.
        bcnt = 0;
        for (int s = 0; s < 4000; s++) begin
            logic p;
            logic b;
            p = (s < 2000) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
            b = (bcnt > 0) || ($urandom_range(19) == 0);
            step(p, $urandom, b);
            if (bcnt > 0) bcnt--;
            if (bus.ser_wr_o) bcnt = $urandom_range(6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cam_word_queue.md
# cam_word_queue

Elastic queue and flow controller upstream of the ESP32 camera-port serializer. Buffers 32-bit event words from the bus-capture logic and issues each one to the serializer as a single-cycle write, only when the serializer is idle, so its 1-deep write queue is never overwritten. Counts words dropped on overflow. Injects a sequence-numbered heartbeat word when the link has been quiet for a programmable time.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 words.
- HEARTBEAT_CYCLES, 54000000: quiet cycles before a heartbeat word is issued; 0 disables heartbeats.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- push_i  in  1  enqueue strobe from capture logic.
- push_data_i  in  32  word to enqueue.
- full_o  out  1  FIFO holds 2^DEPTH_LOG2 words.
- level_o  out  DEPTH_LOG2+1  current FIFO occupancy.
- drop_count_o  out  16  words dropped because FIFO was full; saturates at 16'hFFFF.
- ser_wr_o  out  1  registered single-cycle write strobe to serializer.
- ser_data_o  out  32  registered word for serializer; holds last issued value.
- ser_busy_i  in  1  serializer busy (active or queued).

## Operation
- FIFO: circular buffer, write/read pointers DEPTH_LOG2+1 bits. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ.
- Push is accepted iff push_i=1 and full_o=0 at that cycle.
  - Push while full: the word is discarded and drop_count_o increments (saturating).
  - A pop in the same cycle does not make room for the push.
  - Simultaneous accepted push and pop leaves level_o unchanged.
- FSM states:
  - IDLE → ISSUE when FIFO is non-empty and ser_busy_i=0. This pops the head word into ser_data_o.
  - IDLE → ISSUE when FIFO is empty, ser_busy_i=0, HEARTBEAT_CYCLES≠0 and quiet_cnt == HEARTBEAT_CYCLES-1. This loads {16'hC0FE, hb_seq} into ser_data_o and increments hb_seq (16-bit, wraps 16'hFFFF→0).
  - FIFO data has priority over a heartbeat.
  - ISSUE → SETTLE unconditionally; ser_wr_o=1 only in ISSUE.
  - SETTLE → IDLE unconditionally. SETTLE covers the serializer's one-cycle busy registration latency.
- quiet_cnt (32-bit) increments each cycle in IDLE with the FIFO empty and ser_busy_i=0. It clears in any other cycle and on a heartbeat issue.
- The FSM never issues while ser_busy_i=1. After any ser_wr_o pulse, the next pulse is at least 3 cycles later.

## Timing
- Reset values:
  - ser_wr_o=0, ser_data_o=0, full_o=0, level_o=0, drop_count_o=0.
  - FSM=IDLE, hb_seq=0, quiet_cnt=0, pointers=0.
- Reset asserted mid-operation flushes the FIFO and aborts any issue; ser_wr_o drops immediately.
- Latency, empty and idle system: push_i in cycle t makes the word visible in cycle t+1, and ser_wr_o=1 with the word on ser_data_o in cycle t+2.
- Back-to-back issue with ser_busy_i stuck low: ser_wr_o pulses every 3 cycles.
- level_o and full_o are registered and update the cycle after a push or pop.
- Heartbeat: first one is issued HEARTBEAT_CYCLES+1 cycles after entering quiet IDLE, then every HEARTBEAT_CYCLES+2 cycles while quiet.

## Test plan
- Single word:
  - Stimulus: after reset, push 32'h12345678 with ser_busy_i=0.
  - Required: ser_wr_o pulses exactly once, 2 cycles later, with ser_data_o=32'h12345678; level_o returns to 0.
- Busy hold-off:
  - Stimulus: hold ser_busy_i=1, push 3 words A, B, C.
  - Required: no ser_wr_o and level_o=3.
  - Stimulus: release busy, model serializer busy as 1 for 40 cycles after each write.
  - Required: A, B, C issued in order, each strictly after busy falls, never while busy.
- Overflow:
  - Stimulus: DEPTH_LOG2=4, busy held 1, push 20 words.
  - Required: full_o=1, level_o=16, drop_count_o=4.
  - Stimulus: release busy.
  - Required: first 16 words emerge in order.
- Simultaneous push/pop:
  - Stimulus: level 1, push in the same cycle the FSM pops.
  - Required: level_o stays 1 and no drop.
  - Stimulus: push while full in the same cycle as a pop.
  - Required: the word is dropped and drop_count_o increments.
- Heartbeat:
  - Stimulus: HEARTBEAT_CYCLES=100, idle system.
  - Required: ser_data_o=32'hC0FE0000 at cycle 101, then 32'hC0FE0001 102 cycles later.
  - Stimulus: a push before the timeout.
  - Required: quiet_cnt restarts.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 during ISSUE with 5 words queued.
  - Required: all outputs go to reset values immediately; after release, no stale word is issued.
